// File: rtl/multi_lane_judge_if.sv
// Judge bus: game-state controls, raw buttons and note arrivals in;
// per-lane judgement pulses plus score/combo totals out.
interface multi_lane_judge_if #(
    parameter int NUM_LANES = 4,
    parameter int SCORE_W   = 16,
    parameter int COMBO_W   = 8
);
    logic                 enable;
    logic                 clear;
    logic [NUM_LANES-1:0] buttons;
    logic [NUM_LANES-1:0] note_arrive;
    logic [NUM_LANES-1:0] delete_note;
    logic [NUM_LANES-1:0] perfect_pulse;
    logic [NUM_LANES-1:0] good_pulse;
    logic [NUM_LANES-1:0] miss_pulse;
    logic [NUM_LANES-1:0] stray_press;
    logic [SCORE_W-1:0]   score;
    logic [COMBO_W-1:0]   combo;
    logic [COMBO_W-1:0]   max_combo;

    // Game controller / note shifter side
    modport master (
        output enable, clear, buttons, note_arrive,
        input  delete_note, perfect_pulse, good_pulse, miss_pulse, stray_press,
               score, combo, max_combo
    );

    // Judge side
    modport slave (
        input  enable, clear, buttons, note_arrive,
        output delete_note, perfect_pulse, good_pulse, miss_pulse, stray_press,
               score, combo, max_combo
    );
endinterface

// File: rtl/multi_lane_judge.sv
// N-lane rhythm hit judge: per-lane button conditioning and note-window
// grading, plus shared combo / max-combo / saturating score accumulation.

// One lane: synchroniser, debouncer, press detect and IDLE/ARMED window FSM.
// Judgement outputs are combinational; the top registers them.
module multi_lane_judge_lane #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WIN_GOOD        = 6,
    parameter int WIN_PERFECT     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic button,
    input  logic note_arrive,
    output logic perfect,
    output logic good,
    output logic miss,
    output logic stray
);
    localparam int T_LAST = 2 * WIN_GOOD;
    localparam int TW     = $clog2(T_LAST + 1);
    localparam int DW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [TW-1:0] T_LAST_V = TW'(T_LAST);
    localparam logic [TW-1:0] PERF_LO  = TW'(WIN_GOOD - WIN_PERFECT);
    localparam logic [TW-1:0] PERF_HI  = TW'(WIN_GOOD + WIN_PERFECT);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, ARMED} state_t;

    logic [1:0]    sync;
    logic          deb;
    logic [DW-1:0] db_cnt;
    logic          press;
    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;

    // Two-flop synchroniser for the asynchronous button level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= '0;
        else      sync <= {sync[0], button};
    end

    // Debounce: accept a new level once it has differed for DEBOUNCE_CYCLES
    // consecutive cycles; press is registered on the accepted rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb    <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync[1] != deb) begin
                if (db_cnt == DB_LAST) begin
                    deb    <= sync[1];
                    db_cnt <= '0;
                    press  <= sync[1];
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Lane FSM state and window timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
        end
    end

    // Next state: a new note always (re)arms, a press or the last window
    // cycle retires the armed note, and leaving play drops everything.
    always_comb begin
        state_n = state;
        timer_n = timer;
        if (!enable) begin
            state_n = IDLE;
            timer_n = '0;
        end else if (note_arrive) begin
            state_n = ARMED;
            timer_n = '0;
        end else if (state == ARMED) begin
            if (press || timer == T_LAST_V) begin
                state_n = IDLE;
                timer_n = '0;
            end else begin
                timer_n = timer + TW'(1);
            end
        end
    end

    // Judgement: a press grades the armed note even if a new note arrives in
    // the same cycle; without a press, a replacing note or window end is a miss.
    always_comb begin
        perfect = 1'b0;
        good    = 1'b0;
        miss    = 1'b0;
        stray   = 1'b0;
        if (enable) begin
            if (state == IDLE) begin
                stray = press;
            end else if (press) begin
                if (timer >= PERF_LO && timer <= PERF_HI) perfect = 1'b1;
                else                                      good    = 1'b1;
            end else if (note_arrive || timer == T_LAST_V) begin
                miss = 1'b1;
            end
        end
    end
endmodule

module multi_lane_judge #(
    parameter int NUM_LANES       = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WIN_GOOD        = 6,
    parameter int WIN_PERFECT     = 2,
    parameter int PERFECT_PTS     = 3,
    parameter int GOOD_PTS        = 1,
    parameter int COMBO_TH        = 10,
    parameter int SCORE_W         = 16,
    parameter int COMBO_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    multi_lane_judge_if.slave bus
);
    localparam int SW1 = SCORE_W + 1;
    localparam int CW1 = COMBO_W + 1;

    logic [NUM_LANES-1:0] hit_perfect, hit_good, hit_miss, hit_stray;
    logic [NUM_LANES-1:0] delete_q, perfect_q, good_q, miss_q, stray_q;
    logic [SW1-1:0]       pts, score_sum;
    logic [CW1-1:0]       hits, combo_sum;
    logic [SCORE_W-1:0]   score_q, score_n;
    logic [COMBO_W-1:0]   combo_q, combo_n, max_q, max_n;

    multi_lane_judge_lane #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .WIN_GOOD        (WIN_GOOD),
        .WIN_PERFECT     (WIN_PERFECT)
    ) u_lane [NUM_LANES-1:0] (
        .clk         (clk),
        .rst         (rst),
        .enable      (bus.enable),
        .button      (bus.buttons),
        .note_arrive (bus.note_arrive),
        .perfect     (hit_perfect),
        .good        (hit_good),
        .miss        (hit_miss),
        .stray       (hit_stray)
    );

    // Per-cycle totals: points and hit count summed over lanes, doubled on a
    // running combo, both saturating; any miss wipes the combo outright.
    always_comb begin
        pts  = '0;
        hits = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (hit_perfect[i]) begin
                pts  = pts + SW1'(PERFECT_PTS);
                hits = hits + CW1'(1);
            end else if (hit_good[i]) begin
                pts  = pts + SW1'(GOOD_PTS);
                hits = hits + CW1'(1);
            end
        end
        if (int'(combo_q) >= COMBO_TH) pts = pts << 1;

        score_sum = {1'b0, score_q} + pts;
        score_n   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

        combo_sum = {1'b0, combo_q} + hits;
        if (|hit_miss) combo_n = '0;
        else           combo_n = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];

        max_n = (combo_n > max_q) ? combo_n : max_q;
    end

    // Output registers: pulses always follow the lanes; totals hold while
    // not playing, and clear wins over same-cycle accumulation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            delete_q  <= '0;
            perfect_q <= '0;
            good_q    <= '0;
            miss_q    <= '0;
            stray_q   <= '0;
            score_q   <= '0;
            combo_q   <= '0;
            max_q     <= '0;
        end else begin
            delete_q  <= hit_perfect | hit_good | hit_miss;
            perfect_q <= hit_perfect;
            good_q    <= hit_good;
            miss_q    <= hit_miss;
            stray_q   <= hit_stray;
            if (bus.clear) begin
                score_q <= '0;
                combo_q <= '0;
                max_q   <= '0;
            end else if (bus.enable) begin
                score_q <= score_n;
                combo_q <= combo_n;
                max_q   <= max_n;
            end
        end
    end

    assign bus.delete_note   = delete_q;
    assign bus.perfect_pulse = perfect_q;
    assign bus.good_pulse    = good_q;
    assign bus.miss_pulse    = miss_q;
    assign bus.stray_press   = stray_q;
    assign bus.score         = score_q;
    assign bus.combo         = combo_q;
    assign bus.max_combo     = max_q;
endmodule
